// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-to-forwarding-controller bundle.
// Valid semantics: id_valid marks the ID-stage fields as a real instruction in
// that cycle; there is no ready. The controller instead answers with stall,
// which is a combinational request to hold PC/IF-ID and re-present the same ID
// instruction next cycle. flush squashes the ID instruction and overrides stall.
interface fwd_hazard_ctrl_if #(
  parameter int REG_BITS = 5
);
  logic                id_valid;
  logic [REG_BITS-1:0] id_rn;
  logic [REG_BITS-1:0] id_rm;
  logic                id_use_imm;
  logic [REG_BITS-1:0] id_rd;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                flush;
  logic                stall;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;

  // Decode side drives the ID fields and consumes the controls.
  modport master (
    output id_valid, id_rn, id_rm, id_use_imm, id_rd, id_reg_write,
           id_mem_read, flush,
    input  stall, fwd_a, fwd_b
  );

  // Forwarding/hazard controller side.
  modport slave (
    input  id_valid, id_rn, id_rm, id_use_imm, id_rd, id_reg_write,
           id_mem_read, flush,
    output stall, fwd_a, fwd_b
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for the 5-stage pipeline.
// Keeps a 2-entry shadow of the EX and MEM destination info and produces
// registered EX operand mux selects plus a combinational load-use stall.
// Select codes: 00 regfile, 01 MEM ALU result, 10 WB write data, 11 immediate.
// WB producers need no forwarding because the regfile writes on the negedge.
module fwd_hazard_ctrl #(
  parameter int REG_BITS = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fwd_hazard_ctrl_if.slave     bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;
  localparam logic [REG_BITS-1:0] ZR = ZERO_REG[REG_BITS-1:0];

  // Shadow pipe: instruction currently in EX and in MEM
  logic                ex_v, ex_wr, ex_ld;
  logic [REG_BITS-1:0] ex_rd;
  logic                mem_v, mem_wr;
  logic [REG_BITS-1:0] mem_rd;

  logic [1:0] fwd_a_q, fwd_b_q;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;
  logic       hit_ex_rn, hit_ex_rm, hit_mem_rn, hit_mem_rm;
  logic       stall_c, bubble;

  // A producer entry matches a source only if it really writes a non-XZR reg
  function automatic logic hit(input logic v, input logic wr,
                               input logic [REG_BITS-1:0] rd,
                               input logic [REG_BITS-1:0] r);
    return v & wr & (rd == r) & (r != ZR);
  endfunction

  // Hazard detection, bubble decision and next select codes
  always_comb begin
    hit_ex_rn  = hit(ex_v, ex_wr, ex_rd, bus.id_rn);
    hit_ex_rm  = hit(ex_v, ex_wr, ex_rd, bus.id_rm);
    hit_mem_rn = hit(mem_v, mem_wr, mem_rd, bus.id_rn);
    hit_mem_rm = hit(mem_v, mem_wr, mem_rd, bus.id_rm);
    // A load in EX cannot supply its data yet; rm only matters if it is used
    stall_c = bus.id_valid & ~bus.flush & ex_ld &
              (hit_ex_rn | (~bus.id_use_imm & hit_ex_rm));
    bubble  = stall_c | bus.flush | ~bus.id_valid;
    fwd_a_nxt = SEL_RF;
    fwd_b_nxt = SEL_RF;
    if (!bubble) begin
      // Nearest producer (EX, becoming MEM) wins over the older one
      if (hit_ex_rn)       fwd_a_nxt = SEL_MEM;
      else if (hit_mem_rn) fwd_a_nxt = SEL_WB;
      if (bus.id_use_imm)  fwd_b_nxt = SEL_IMM;
      else if (hit_ex_rm)  fwd_b_nxt = SEL_MEM;
      else if (hit_mem_rm) fwd_b_nxt = SEL_WB;
    end
  end

  // Advance the shadow pipe and register the selects for the EX stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_v    <= 1'b0;
      ex_wr   <= 1'b0;
      ex_ld   <= 1'b0;
      ex_rd   <= '0;
      mem_v   <= 1'b0;
      mem_wr  <= 1'b0;
      mem_rd  <= '0;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
    end else begin
      mem_v  <= ex_v;
      mem_wr <= ex_wr;
      mem_rd <= ex_rd;
      if (bubble) begin
        ex_v  <= 1'b0;
        ex_wr <= 1'b0;
        ex_ld <= 1'b0;
        ex_rd <= '0;
      end else begin
        ex_v  <= 1'b1;
        ex_wr <= bus.id_reg_write;
        ex_ld <= bus.id_mem_read;
        ex_rd <= bus.id_rd;
      end
      fwd_a_q <= fwd_a_nxt;
      fwd_b_q <= fwd_b_nxt;
    end
  end

  assign bus.stall = stall_c;
  assign bus.fwd_a = fwd_a_q;
  assign bus.fwd_b = fwd_b_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl. Each issued ID vector pushes its expected
// stall and its expected EX-stage select pair; two monitors pop and compare.
module tb_fwd_hazard_ctrl;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  logic [0:0] stall_q[$];
  logic [3:0] fwd_q[$];

  fwd_hazard_ctrl_if #(.REG_BITS(5)) bus ();

  fwd_hazard_ctrl #(.REG_BITS(5), .ZERO_REG(31)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one call per cycle, applied 2 time units after the rising edge
  task automatic issue(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic imm, input logic [4:0] rd, input logic wr,
                       input logic ld, input logic fl, input logic exp_stall,
                       input logic [1:0] exp_a, input logic [1:0] exp_b);
    @(posedge clk);
    #2;
    bus.id_valid     = v;
    bus.id_rn        = rn;
    bus.id_rm        = rm;
    bus.id_use_imm   = imm;
    bus.id_rd        = rd;
    bus.id_reg_write = wr;
    bus.id_mem_read  = ld;
    bus.flush        = fl;
    stall_q.push_back(exp_stall);
    fwd_q.push_back({exp_a, exp_b});
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  // Stall monitor: combinational output checked mid-cycle
  always @(negedge clk) begin
    logic [0:0] e;
    if (stall_q.size() > 0) begin
      e = stall_q.pop_front();
      check("stall", {3'b0, bus.stall}, {3'b0, e});
    end
  end

  // Select monitor: registered outputs checked just after the edge
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (fwd_q.size() > 0) begin
      e = fwd_q.pop_front();
      check("fwd_ab", {bus.fwd_a, bus.fwd_b}, e);
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    bus.id_valid = 1'b0; bus.id_rn = '0; bus.id_rm = '0; bus.id_use_imm = 1'b0;
    bus.id_rd = '0; bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.flush = 1'b0;
    #3;
    check("reset_stall", {3'b0, bus.stall}, 4'b0);
    check("reset_fwd", {bus.fwd_a, bus.fwd_b}, 4'b0);
    @(negedge clk);
    reset_n = 1'b1;

    //     v   rn     rm     imm   rd     wr    ld    fl    stl   a      b
    // 1: ADD X1 ; ADD X2,X1,X3 -> 01/00
    issue(1, 5'd2, 5'd3, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    issue(1, 5'd1, 5'd3, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    nop(); nop();
    // 2: ADD X1 ; NOP ; SUB X4,X3,X1 -> 00/10
    issue(1, 5'd2, 5'd3, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    nop();
    issue(1, 5'd3, 5'd1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
    nop(); nop();
    // 3: LDUR X5 ; ADD X6,X5,X5 -> one stall, then 10/10
    issue(1, 5'd9, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
    issue(1, 5'd5, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    issue(1, 5'd5, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
    nop(); nop();
    // 4: LDUR X5 ; dependent ADD flushed -> no stall, bubble
    issue(1, 5'd9, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
    issue(1, 5'd5, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    nop(); nop();
    // 5: XZR never forwarded nor a hazard
    issue(1, 5'd2, 5'd3, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    issue(1, 5'd31, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
    issue(1, 5'd9, 5'd0, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
    issue(1, 5'd31, 5'd31, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    // X1 written by both EX and MEM entries: nearest wins
    issue(1, 5'd2, 5'd3, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    issue(1, 5'd2, 5'd3, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    issue(1, 5'd1, 5'd1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
    // Non-writing producer ignored; rm from MEM
    issue(1, 5'd2, 5'd3, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    issue(1, 5'd10, 5'd9, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
    // Load followed by immediate-form user of rm only: no stall
    issue(1, 5'd9, 5'd0, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
    issue(1, 5'd3, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
    nop(); nop();

    // 6: async reset with a load in EX and a dependent in ID
    issue(1, 5'd9, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
    @(posedge clk);
    #2;
    bus.id_valid = 1'b1; bus.id_rn = 5'd5; bus.id_rm = 5'd5; bus.id_use_imm = 1'b0;
    bus.id_rd = 5'd6; bus.id_reg_write = 1'b1; bus.id_mem_read = 1'b0; bus.flush = 1'b0;
    #1;
    check("pre_reset_stall", {3'b0, bus.stall}, 4'b0001);
    reset_n = 1'b0;
    #1;
    check("async_reset_stall", {3'b0, bus.stall}, 4'b0);
    check("async_reset_fwd", {bus.fwd_a, bus.fwd_b}, 4'b0);
    bus.id_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    // First instruction after reset sees no producers
    issue(1, 5'd5, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    nop();

    // Drain with a cycle budget
    begin
      int budget;
      budget = 0;
      while ((stall_q.size() > 0 || fwd_q.size() > 0) && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      #6;
      n_tests++;
      if (stall_q.size() > 0 || fwd_q.size() > 0) begin
        n_fail++;
        $display("FAIL drain: %0d stall and %0d fwd entries left, expected 0",
                 stall_q.size(), fwd_q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
